fir_seq_ctrl: RTL and testbench
===============================

// Module: fir_seq_ctrl
// PURPOSE
//  Sequencer between the FIR IP's AXI4-Lite register bank and the FIR datapath core.
//  - Loads the coefficient shadow memory into the core's tap registers.
//  - Paces input samples into the core at a programmed rate.
//  - Flushes the delay line on stop; reports state, sample count and sticky errors.
// PARAMETERS
//  N_TAPS  16  number of FIR taps / coefficients
//  DATA_W  16  sample width
//  COEF_W  16  coefficient width
//  DIV_W   16  rate-divider width
// PORTS
//  ACLK           in   1                single clock, all logic rising-edge
//  ARESET         in   1                synchronous, active-high reset
//  cfg_start      in   1                1-cycle pulse from ctrl register: begin streaming
//  cfg_stop       in   1                1-cycle pulse: stop streaming and flush
//  cfg_coef_load  in   1                1-cycle pulse: copy shadow coefs to core
//  cfg_err_clr    in   1                1-cycle pulse: clear sticky errors
//  cfg_rate_div   in   DIV_W            one sample issued every rate_div+1 cycles
//  shd_rd_addr    out  clog2(N_TAPS)    shadow-coef read address (1-cycle read latency)
//  shd_rd_data    in   COEF_W           shadow-coef read data
//  coef_wr_en     out  1                core tap write strobe
//  coef_wr_addr   out  clog2(N_TAPS)    core tap index
//  coef_wr_data   out  COEF_W           core tap value
//  smp_valid      in   1                upstream sample available
//  smp_data       in   DATA_W           upstream sample
//  smp_ready      out  1                sample consumed this cycle
//  fir_in_valid   out  1                sample strobe into core
//  fir_in_data    out  DATA_W           sample into core (zero during flush)
//  st_state       out  3                encoded FSM state
//  st_coefs_ok    out  1                coefficients loaded since reset
//  st_smp_cnt     out  32               samples issued in RUN, wraps at 2^32
//  st_underrun    out  DIV_W            missed ticks, saturating
//  st_err         out  2                sticky: [0] start without coefs, [1] load while busy
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; st_coefs_ok, counters and stickies cleared.
//    Reset mid-LOAD leaves core taps partially written; st_coefs_ok=0.
//  - States: IDLE=0, LOAD=1, RUN=2, FLUSH=3.
//  - IDLE, event priority:
//    - cfg_coef_load -> LOAD; a coincident cfg_start is dropped.
//    - Else cfg_start with st_coefs_ok=1 -> RUN; st_smp_cnt and tick counter zeroed.
//    - Else cfg_start with st_coefs_ok=0 -> set st_err[0], stay IDLE.
//    - cfg_stop in IDLE is ignored.
//  - LOAD, pipelined:
//    - Cycle k (0..N_TAPS-1): shd_rd_addr=k.
//    - Cycle k+1: coef_wr_en=1, coef_wr_addr=k, coef_wr_data=shd_rd_data.
//    - Lasts exactly N_TAPS+1 cycles, then st_coefs_ok=1 and -> IDLE.
//    - cfg_start/cfg_stop are ignored; cfg_coef_load sets st_err[1].
//  - RUN:
//    - Tick counter counts 0..cfg_rate_div, sampled live; a tick fires at terminal count.
//    - cfg_rate_div=0: tick every cycle.
//    - Tick with smp_valid=1: fir_in_valid=smp_ready=1 for that cycle, fir_in_data=smp_data, st_smp_cnt++.
//    - Tick with smp_valid=0: no strobe, st_underrun++ (saturates at all-ones).
//    - smp_ready is never asserted outside a tick.
//    - cfg_coef_load sets st_err[1] and is ignored.
//    - cfg_stop -> FLUSH; it takes priority over a coincident tick, so no sample is issued that cycle.
//  - FLUSH:
//    - N_TAPS consecutive cycles of fir_in_valid=1 with fir_in_data=0, then -> IDLE.
//    - Not counted in st_smp_cnt; smp_ready=0; cfg_start is ignored.
//  - cfg_err_clr clears st_err in any state. A coincident new error wins (the bit stays set).
//  - st_underrun clears on entry to RUN.
//  - All outputs are registered; output latency is 1 cycle from the decision cycle.
// STRUCTURE
//  - fir_ctrl_pkg:
//    - state enum (fir_seq_state_t, 3-bit).
//    - err bit indices ERR_NO_COEF=0, ERR_LOAD_BUSY=1.
//    - default widths.
//  - Sub-module fir_rate_ticker: DIV_W counter with clr, en, div inputs and a tick output.
//  - FSM, load pipeline and status counters live in the top.
// TESTING
//  - Load: N_TAPS=16, shadow holds k*3+1 -> 16 writes on consecutive cycles, addr 0..15, data 1..46; st_coefs_ok=1 after 17 cycles.
//  - Start without coefs: pulse cfg_start after reset -> st_err=2'b01, state stays IDLE, no fir_in_valid.
//  - Pacing: rate_div=3, smp_valid held 1, 40 cycles of RUN -> fir_in_valid every 4th cycle, st_smp_cnt=10, st_underrun=0.
//  - Underrun: rate_div=0, smp_valid toggles 1/0 -> alternate strobes; st_underrun counts the gaps (8 over 16 ticks).
//  - Stop/flush: cfg_stop coincident with a tick -> no sample that cycle, then 16 zero strobes, then IDLE, st_smp_cnt unchanged.
//  - Priority/reset: cfg_coef_load+cfg_start same cycle -> LOAD, no RUN; ARESET at load cycle 5 -> IDLE, st_coefs_ok=0, all outputs 0.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR sequencer.
// Contents: FSM state encoding, sticky error bit indices, default widths,
// and a helper that sizes tap-index buses.
package fir_ctrl_pkg;

    localparam int DEF_N_TAPS = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_DIV_W  = 16;
    localparam int SMP_CNT_W  = 32;

    // Sticky error register layout.
    localparam int ERR_W         = 2;
    localparam int ERR_NO_COEF   = 0;
    localparam int ERR_LOAD_BUSY = 1;

    // Encoding is visible to software through the status register.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3
    } fir_seq_state_t;

    // Width of a tap index; a single-tap filter still gets a 1-bit bus.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Bundle of every non-clock signal between the sequencer and its neighbours:
// register-bank controls, shadow-coef read port, core tap write port,
// upstream sample handshake, core sample input and status readback.
// master = sequencer side, slave = register bank / shadow RAM / core / source.
interface fir_seq_ctrl_if import fir_ctrl_pkg::*; #(
    parameter int N_TAPS = DEF_N_TAPS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int DIV_W  = DEF_DIV_W
) ();
    localparam int AW = addr_w(N_TAPS);

    // control pulses and rate from the register bank
    logic                 cfg_start;
    logic                 cfg_stop;
    logic                 cfg_coef_load;
    logic                 cfg_err_clr;
    logic [DIV_W-1:0]     cfg_rate_div;
    // shadow coefficient memory read port
    logic [AW-1:0]        shd_rd_addr;
    logic [COEF_W-1:0]    shd_rd_data;
    // core tap write port
    logic                 coef_wr_en;
    logic [AW-1:0]        coef_wr_addr;
    logic [COEF_W-1:0]    coef_wr_data;
    // upstream samples
    logic                 smp_valid;
    logic [DATA_W-1:0]    smp_data;
    logic                 smp_ready;
    // core sample input
    logic                 fir_in_valid;
    logic [DATA_W-1:0]    fir_in_data;
    // status
    fir_seq_state_t       st_state;
    logic                 st_coefs_ok;
    logic [SMP_CNT_W-1:0] st_smp_cnt;
    logic [DIV_W-1:0]     st_underrun;
    logic [ERR_W-1:0]     st_err;

    modport master (
        input  cfg_start, cfg_stop, cfg_coef_load, cfg_err_clr, cfg_rate_div,
        input  shd_rd_data, smp_valid, smp_data,
        output shd_rd_addr, coef_wr_en, coef_wr_addr, coef_wr_data,
        output smp_ready, fir_in_valid, fir_in_data,
        output st_state, st_coefs_ok, st_smp_cnt, st_underrun, st_err
    );

    modport slave (
        output cfg_start, cfg_stop, cfg_coef_load, cfg_err_clr, cfg_rate_div,
        output shd_rd_data, smp_valid, smp_data,
        input  shd_rd_addr, coef_wr_en, coef_wr_addr, coef_wr_data,
        input  smp_ready, fir_in_valid, fir_in_data,
        input  st_state, st_coefs_ok, st_smp_cnt, st_underrun, st_err
    );

endinterface

// File: rtl/fir_rate_ticker.sv
// Purpose : sample-rate pacer; counts 0..div and flags the terminal count.
// Latency : tick is combinational from the count register and live div.
// Backpr. : none; en freezes the count, clr restarts it from zero.
// Ports   : ACLK/ARESET clock and sync reset; clr, en, div in; tick out.
module fir_rate_ticker #(
    parameter int DIV_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q;

    // >= rather than == so that lowering div mid-count fires at once instead
    // of letting the counter run all the way round.
    assign tick = en && (cnt_q >= div);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Purpose : sequencer between the FIR register bank and the FIR core: loads
//           taps from shadow RAM, paces samples in, flushes on stop.
// Latency : one cycle from decision to registered outputs; tap write data
//           passes straight through from the shadow RAM read port.
// Backpr. : samples are taken only on a rate tick; smp_ready marks the take,
//           a tick with no sample counts as an underrun.
// Ports   : ACLK, ARESET (sync, active high) and the master side of
//           fir_seq_ctrl_if carrying control, RAM, core, sample and status.
module fir_seq_ctrl import fir_ctrl_pkg::*; #(
    parameter int N_TAPS = DEF_N_TAPS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic          ACLK,
    input  logic          ARESET,
    fir_seq_ctrl_if.master bus
);
    localparam int AW = addr_w(N_TAPS);
    // One extra bit so the load sequencer can count to N_TAPS inclusive.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_TAPS - 1);
    localparam logic [CW-1:0] LOAD_END = CW'(N_TAPS);

    fir_seq_state_t       state_q,    state_d;
    logic [CW-1:0]        seq_cnt_q,  seq_cnt_d;
    logic [AW-1:0]        shd_addr_q, shd_addr_d;
    logic                 wr_en_q,    wr_en_d;
    logic [AW-1:0]        wr_addr_q,  wr_addr_d;
    logic                 in_vld_q,   in_vld_d;
    logic [DATA_W-1:0]    in_dat_q,   in_dat_d;
    logic                 rdy_q,      rdy_d;
    logic                 coefs_ok_q, coefs_ok_d;
    logic [SMP_CNT_W-1:0] smp_cnt_q,  smp_cnt_d;
    logic [DIV_W-1:0]     underrun_q, underrun_d;
    logic [ERR_W-1:0]     err_q,      err_d;
    logic [ERR_W-1:0]     err_set;
    logic                 tick_clr;
    logic                 tick;

    fir_rate_ticker #(.DIV_W(DIV_W)) u_ticker (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .clr    (tick_clr),
        .en     (state_q == ST_RUN),
        .div    (bus.cfg_rate_div),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        seq_cnt_d  = seq_cnt_q;
        shd_addr_d = '0;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        in_vld_d   = 1'b0;
        in_dat_d   = '0;
        rdy_d      = 1'b0;
        coefs_ok_d = coefs_ok_q;
        smp_cnt_d  = smp_cnt_q;
        underrun_d = underrun_q;
        err_set    = '0;
        tick_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A load request swallows a coincident start without error.
                if (bus.cfg_coef_load) begin
                    state_d   = ST_LOAD;
                    seq_cnt_d = '0;
                end else if (bus.cfg_start) begin
                    if (coefs_ok_q) begin
                        state_d    = ST_RUN;
                        smp_cnt_d  = '0;
                        underrun_d = '0;
                        tick_clr   = 1'b1;
                    end else begin
                        err_set[ERR_NO_COEF] = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                // seq_cnt counts load cycles 0..N_TAPS. Address k is on the
                // RAM in cycle k; its data returns in cycle k+1, which is
                // when the registered write strobe for tap k is high.
                if (bus.cfg_coef_load) begin
                    err_set[ERR_LOAD_BUSY] = 1'b1;
                end
                if (seq_cnt_q == LOAD_END) begin
                    state_d    = ST_IDLE;
                    seq_cnt_d  = '0;
                    coefs_ok_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = seq_cnt_q[AW-1:0];
                    if (seq_cnt_q < LAST_IDX) begin
                        shd_addr_d = AW'(seq_cnt_q + CW'(1));
                    end
                    seq_cnt_d = seq_cnt_q + CW'(1);
                end
            end

            ST_RUN: begin
                if (bus.cfg_coef_load) begin
                    err_set[ERR_LOAD_BUSY] = 1'b1;
                end
                // Stop beats a coincident tick: the first flush strobe goes
                // out instead of a sample, and nothing is counted.
                if (bus.cfg_stop) begin
                    state_d   = ST_FLUSH;
                    seq_cnt_d = '0;
                    in_vld_d  = 1'b1;
                end else if (tick) begin
                    if (bus.smp_valid) begin
                        in_vld_d  = 1'b1;
                        in_dat_d  = bus.smp_data;
                        rdy_d     = 1'b1;
                        smp_cnt_d = smp_cnt_q + SMP_CNT_W'(1);
                    end else if (underrun_q != '1) begin
                        underrun_d = underrun_q + DIV_W'(1);
                    end
                end
            end

            ST_FLUSH: begin
                // Flush is still a busy phase for the tap registers' owner.
                if (bus.cfg_coef_load) begin
                    err_set[ERR_LOAD_BUSY] = 1'b1;
                end
                // The strobe for flush cycle 0 was issued on the stop cycle;
                // keep one strobe per cycle until cycle N_TAPS-1.
                if (seq_cnt_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    seq_cnt_d = '0;
                end else begin
                    in_vld_d  = 1'b1;
                    seq_cnt_d = seq_cnt_q + CW'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                seq_cnt_d = '0;
            end
        endcase

        // Setting wins over clearing so an error in the clear cycle is kept.
        err_d = (bus.cfg_err_clr ? '0 : err_q) | err_set;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            seq_cnt_q  <= '0;
            shd_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            in_vld_q   <= 1'b0;
            in_dat_q   <= '0;
            rdy_q      <= 1'b0;
            coefs_ok_q <= 1'b0;
            smp_cnt_q  <= '0;
            underrun_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            seq_cnt_q  <= seq_cnt_d;
            shd_addr_q <= shd_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            in_vld_q   <= in_vld_d;
            in_dat_q   <= in_dat_d;
            rdy_q      <= rdy_d;
            coefs_ok_q <= coefs_ok_d;
            smp_cnt_q  <= smp_cnt_d;
            underrun_q <= underrun_d;
            err_q      <= err_d;
        end
    end

    assign bus.shd_rd_addr  = shd_addr_q;
    assign bus.coef_wr_en   = wr_en_q;
    assign bus.coef_wr_addr = wr_addr_q;
    // The RAM's read register already aligns the data with the strobe;
    // gating keeps the port at zero whenever no write is in progress.
    assign bus.coef_wr_data = wr_en_q ? bus.shd_rd_data : '0;
    assign bus.smp_ready    = rdy_q;
    assign bus.fir_in_valid = in_vld_q;
    assign bus.fir_in_data  = in_dat_q;
    assign bus.st_state     = state_q;
    assign bus.st_coefs_ok  = coefs_ok_q;
    assign bus.st_smp_cnt   = smp_cnt_q;
    assign bus.st_underrun  = underrun_q;
    assign bus.st_err       = err_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: reset, start without coefficients,
// load/start priority and tap load, pacing, underrun, stop/flush, errors,
// and reset during a load.
module tb_fir_seq_ctrl;
    import fir_ctrl_pkg::*;

    localparam int N_TAPS = 16;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int DIV_W  = 16;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [COEF_W-1:0] shadow [N_TAPS];
    logic              exp_v;

    fir_seq_ctrl_if #(.N_TAPS(N_TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .DIV_W(DIV_W)) bus ();

    fir_seq_ctrl #(.N_TAPS(N_TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .DIV_W(DIV_W)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    always #5 ACLK = ~ACLK;

    // Shadow RAM with one-cycle read latency.
    always @(posedge ACLK) bus.shd_rd_data <= shadow[bus.shd_rd_addr];

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"},    bus.st_state,     64'(ST_IDLE));
        chk({tag, "_coefs_ok"}, bus.st_coefs_ok,  0);
        chk({tag, "_err"},      bus.st_err,       0);
        chk({tag, "_smp_cnt"},  bus.st_smp_cnt,   0);
        chk({tag, "_underrun"}, bus.st_underrun,  0);
        chk({tag, "_in_vld"},   bus.fir_in_valid, 0);
        chk({tag, "_in_dat"},   bus.fir_in_data,  0);
        chk({tag, "_rdy"},      bus.smp_ready,    0);
        chk({tag, "_wr_en"},    bus.coef_wr_en,   0);
        chk({tag, "_wr_addr"},  bus.coef_wr_addr, 0);
        chk({tag, "_wr_dat"},   bus.coef_wr_data, 0);
        chk({tag, "_shd_addr"}, bus.shd_rd_addr,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N_TAPS; k++) shadow[k] = COEF_W'(k * 3 + 1);
        bus.cfg_start     = 1'b0;
        bus.cfg_stop      = 1'b0;
        bus.cfg_coef_load = 1'b0;
        bus.cfg_err_clr   = 1'b0;
        bus.cfg_rate_div  = '0;
        bus.smp_valid     = 1'b0;
        bus.smp_data      = '0;

        // ---- reset ----
        cyc();
        cyc();
        check_all_zero("reset");
        ARESET = 1'b0;

        // ---- start without coefficients ----
        bus.cfg_start = 1'b1;
        cyc();
        bus.cfg_start = 1'b0;
        chk("nocoef_err",   bus.st_err,       2'b01);
        chk("nocoef_state", bus.st_state,     64'(ST_IDLE));
        chk("nocoef_vld",   bus.fir_in_valid, 0);
        cyc();
        chk("nocoef_vld2",  bus.fir_in_valid, 0);
        bus.cfg_err_clr = 1'b1;
        cyc();
        bus.cfg_err_clr = 1'b0;
        chk("errclr", bus.st_err, 0);

        // ---- load + start together: load wins, start dropped ----
        bus.cfg_coef_load = 1'b1;
        bus.cfg_start     = 1'b1;
        cyc();
        bus.cfg_coef_load = 1'b0;
        bus.cfg_start     = 1'b0;
        chk("load_l0_state", bus.st_state,    64'(ST_LOAD));
        chk("load_l0_addr",  bus.shd_rd_addr, 0);
        chk("load_l0_wr_en", bus.coef_wr_en,  0);
        for (int k = 0; k < N_TAPS; k++) begin
            cyc();
            // now in load cycle k+1: tap k is being written
            chk("load_state", bus.st_state,     64'(ST_LOAD));
            chk("load_wr_en", bus.coef_wr_en,   1);
            chk("load_wr_ad", bus.coef_wr_addr, k);
            chk("load_wr_dt", bus.coef_wr_data, k * 3 + 1);
            if (k < N_TAPS - 1) chk("load_rd_ad", bus.shd_rd_addr, k + 1);
            if (k == 4) chk("load_ok_mid", bus.st_coefs_ok, 0);
        end
        cyc();
        chk("load_done_state", bus.st_state,    64'(ST_IDLE));
        chk("load_done_ok",    bus.st_coefs_ok, 1);
        chk("load_done_wr_en", bus.coef_wr_en,  0);
        chk("load_done_err",   bus.st_err,      0);

        // ---- pacing: rate_div=3, source always valid ----
        bus.cfg_rate_div = 16'd3;
        bus.smp_valid    = 1'b1;
        bus.smp_data     = 16'hA0FF;
        bus.cfg_start    = 1'b1;
        cyc();
        bus.cfg_start = 1'b0;
        chk("run_entry_state", bus.st_state,   64'(ST_RUN));
        chk("run_entry_cnt",   bus.st_smp_cnt, 0);
        for (int i = 0; i < 40; i++) begin
            exp_v = (i >= 4) && (i % 4 == 0);
            chk("pace_vld", bus.fir_in_valid, exp_v);
            chk("pace_rdy", bus.smp_ready,    exp_v);
            if (exp_v) chk("pace_dat", bus.fir_in_data, 16'hA000 + i - 1);
            bus.smp_data = 16'hA000 + 16'(i);
            cyc();
        end
        chk("pace_last_vld", bus.fir_in_valid, 1);
        chk("pace_last_dat", bus.fir_in_data,  16'hA027);
        chk("pace_cnt",      bus.st_smp_cnt,   10);
        chk("pace_underrun", bus.st_underrun,  0);

        // ---- stop coincident with a tick, then flush ----
        repeat (3) cyc();
        bus.cfg_stop = 1'b1;
        cyc();
        bus.cfg_stop = 1'b0;
        for (int j = 0; j < N_TAPS; j++) begin
            chk("flush_state", bus.st_state,     64'(ST_FLUSH));
            chk("flush_vld",   bus.fir_in_valid, 1);
            chk("flush_dat",   bus.fir_in_data,  0);
            chk("flush_rdy",   bus.smp_ready,    0);
            bus.cfg_start = (j == 3);
            cyc();
        end
        bus.cfg_start = 1'b0;
        chk("flush_end_state", bus.st_state,     64'(ST_IDLE));
        chk("flush_end_vld",   bus.fir_in_valid, 0);
        chk("flush_end_cnt",   bus.st_smp_cnt,   10);
        chk("flush_end_under", bus.st_underrun,  0);

        // ---- underrun: tick every cycle, source alternates ----
        bus.cfg_rate_div = 16'd0;
        bus.cfg_start    = 1'b1;
        cyc();
        bus.cfg_start = 1'b0;
        chk("ur_entry_state", bus.st_state, 64'(ST_RUN));
        for (int i = 0; i < 16; i++) begin
            bus.smp_valid     = (i % 2 == 0);
            bus.smp_data      = 16'hB000 + 16'(i);
            bus.cfg_coef_load = (i == 5);
            cyc();
            chk("ur_vld", bus.fir_in_valid, (i % 2 == 0));
            chk("ur_rdy", bus.smp_ready,    (i % 2 == 0));
            if (i % 2 == 0) chk("ur_dat", bus.fir_in_data, 16'hB000 + i);
            if (i == 5) begin
                chk("busy_err",   bus.st_err,   2'b10);
                chk("busy_state", bus.st_state, 64'(ST_RUN));
            end
        end
        bus.cfg_coef_load = 1'b0;
        bus.smp_valid     = 1'b0;
        chk("ur_cnt",      bus.st_smp_cnt,  8);
        chk("ur_underrun", bus.st_underrun, 8);

        // error set and clear in the same cycle: set wins
        bus.cfg_err_clr   = 1'b1;
        bus.cfg_coef_load = 1'b1;
        cyc();
        bus.cfg_coef_load = 1'b0;
        chk("clr_vs_set", bus.st_err, 2'b10);
        cyc();
        bus.cfg_err_clr = 1'b0;
        chk("clr_only",  bus.st_err,      0);
        chk("ur_grow",   bus.st_underrun, 10);

        bus.cfg_stop = 1'b1;
        cyc();
        bus.cfg_stop = 1'b0;
        repeat (N_TAPS) cyc();
        chk("ur_stop_state", bus.st_state,    64'(ST_IDLE));
        chk("ur_hold",       bus.st_underrun, 10);

        // underrun and sample count clear on entry to RUN
        bus.cfg_start = 1'b1;
        cyc();
        bus.cfg_start = 1'b0;
        chk("restart_state", bus.st_state,    64'(ST_RUN));
        chk("restart_under", bus.st_underrun, 0);
        chk("restart_cnt",   bus.st_smp_cnt,  0);
        bus.cfg_stop = 1'b1;
        cyc();
        bus.cfg_stop = 1'b0;
        repeat (N_TAPS) cyc();
        chk("restart_idle", bus.st_state, 64'(ST_IDLE));

        // ---- reset in load cycle 5 ----
        bus.cfg_coef_load = 1'b1;
        cyc();
        bus.cfg_coef_load = 1'b0;
        repeat (5) cyc();
        chk("rl_state",   bus.st_state,     64'(ST_LOAD));
        chk("rl_wr_en",   bus.coef_wr_en,   1);
        chk("rl_wr_addr", bus.coef_wr_addr, 4);
        chk("rl_wr_data", bus.coef_wr_data, 13);
        ARESET = 1'b1;
        cyc();
        check_all_zero("rst_load");
        ARESET = 1'b0;
        bus.cfg_start = 1'b1;
        cyc();
        bus.cfg_start = 1'b0;
        chk("rl_nocoef_err",   bus.st_err,   2'b01);
        chk("rl_nocoef_state", bus.st_state, 64'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
